// File: rtl/rbm_dma_pkg.sv
// Shared state encoding, size defaults and LFSR constants for the RBM DMA responder.
package rbm_dma_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        IDLE,
        RD_GNT,
        RD_STRM,
        WR_GNT,
        WR_STRM
    } dma_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/rbm_dma_mem.sv
// Word memory: one stream write port, one backdoor load port, one async read port.
// A stream write and a load to the same word in the same cycle leave the stream data.
module rbm_dma_mem
    import rbm_dma_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              st_we,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Stream write is issued last so it overrides a colliding load.
    always_ff @(posedge clk) begin
        if (ld_en) mem_q[ld_addr] <= ld_data;
        if (st_we) mem_q[st_addr] <= st_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rbm_dma_responder.sv
// Memory-side DMA responder: grants one read or write request at a time and streams words.
// Optional RBM_DMA_STALL_EN inserts LFSR-driven stall cycles into both streams.
module rbm_dma_responder
    import rbm_dma_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_request,
    input  logic [31:0]       rd_index,
    input  logic [31:0]       rd_length,
    output logic              rd_grant,
    output logic              data_in_valid,
    output logic [DATA_W-1:0] data_in_data,
    input  logic              data_in_ready,
    input  logic              wr_request,
    input  logic [31:0]       wr_index,
    input  logic [31:0]       wr_length,
    output logic              wr_grant,
    input  logic              data_out_valid,
    input  logic [DATA_W-1:0] data_out_data,
    output logic              data_out_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       rem_q, rem_d;
    logic              go;
    logic              rd_xfer;
    logic              wr_xfer;
    logic [DATA_W-1:0] rd_word;
    logic              unused_idx;

    assign unused_idx = ^{rd_index[31:ADDR_W], wr_index[31:ADDR_W]};

`ifdef RBM_DMA_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);
    assign go     = lfsr_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign go = 1'b1;
`endif

    // Handshake outputs decode straight from the state so reset clears them at once.
    assign rd_grant       = (state_q == RD_GNT);
    assign wr_grant       = (state_q == WR_GNT);
    assign busy           = (state_q != IDLE);
    assign data_in_valid  = (state_q == RD_STRM) && go;
    assign data_out_ready = (state_q == WR_STRM) && go;
    assign data_in_data   = data_in_valid ? rd_word : '0;
    assign rd_xfer        = data_in_valid && data_in_ready;
    assign wr_xfer        = data_out_ready && data_out_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (rd_request)      state_d = RD_GNT;
                else if (wr_request) state_d = WR_GNT;
            end
            RD_GNT: begin
                ptr_d   = rd_index[ADDR_W-1:0];
                rem_d   = rd_length;
                state_d = (rd_length == 32'd0) ? IDLE : RD_STRM;
            end
            RD_STRM: begin
                if (rd_xfer) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) state_d = IDLE;
                end
            end
            WR_GNT: begin
                ptr_d   = wr_index[ADDR_W-1:0];
                rem_d   = wr_length;
                state_d = (wr_length == 32'd0) ? IDLE : WR_STRM;
            end
            WR_STRM: begin
                if (wr_xfer) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    rbm_dma_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .st_we   (wr_xfer),
        .st_addr (ptr_q),
        .st_data (data_out_data),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (ptr_q),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_rbm_dma_responder.sv
// Directed bench for rbm_dma_responder; a 16-word memory model feeds a scoreboard queue.
module tb_rbm_dma_responder;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_request = 1'b0;
    logic [31:0]   rd_index = '0;
    logic [31:0]   rd_length = '0;
    logic          rd_grant;
    logic          data_in_valid;
    logic [DW-1:0] data_in_data;
    logic          data_in_ready = 1'b0;
    logic          wr_request = 1'b0;
    logic [31:0]   wr_index = '0;
    logic [31:0]   wr_length = '0;
    logic          wr_grant;
    logic          data_out_valid = 1'b0;
    logic [DW-1:0] data_out_data = '0;
    logic          data_out_ready;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          busy;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            failures = 0;

    rbm_dma_responder #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_request     (rd_request),
        .rd_index       (rd_index),
        .rd_length      (rd_length),
        .rd_grant       (rd_grant),
        .data_in_valid  (data_in_valid),
        .data_in_data   (data_in_data),
        .data_in_ready  (data_in_ready),
        .wr_request     (wr_request),
        .wr_index       (wr_index),
        .wr_length      (wr_length),
        .wr_grant       (wr_grant),
        .data_out_valid (data_out_valid),
        .data_out_data  (data_out_data),
        .data_out_ready (data_out_ready),
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    task automatic push_exp(input int idx, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(model[(idx + i) % DEPTH]);
    endtask

    task automatic request_read(input logic [31:0] idx, input logic [31:0] len);
        rd_index   = idx;
        rd_length  = len;
        rd_request = 1'b1;
        tick();
        chk("rd_grant_lat", 32'({busy, rd_grant, wr_grant}), 32'b110);
        rd_request = 1'b0;
    endtask

    task automatic request_write(input logic [31:0] idx);
        wr_index   = idx;
        wr_length  = 32'd2;
        wr_request = 1'b1;
        tick();
        chk("wr_grant_lat", 32'({busy, rd_grant, wr_grant}), 32'b101);
        wr_request = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready low 5 cycles after first word, 2: random ready
    task automatic run_read_stream(input int len, input int mode, output int gaps);
        int            n = 1;
        int            got = 0;
        int            hold = 0;
        bit            seen = 0;
        bit            prev_stall = 0;
        bit            done = 0;
        logic [DW-1:0] prev_d = '0;
        gaps = 0;
        while (!done) begin
            tick();
            n++;
            if (!busy) begin
                done = 1;
                data_in_ready = 1'b0;
`ifndef RBM_DMA_STALL_EN
                if (mode == 0) chk("rd_busy_drop", n, len + 2);
`endif
                chk("rd_count", got, len);
            end else if (n > BUDGET) begin
                done = 1;
                data_in_ready = 1'b0;
                chk("rd_timeout", got, len);
            end else begin
                case (mode)
                    0:       data_in_ready = 1'b1;
                    1:       data_in_ready = !(got == 1 && hold < 5);
                    default: data_in_ready = ($urandom_range(0, 1) == 1);
                endcase
                if (mode == 1 && got == 1 && !data_in_ready) hold++;
                chk("rd_no_grant", 32'({rd_grant, wr_grant}), 32'd0);
                if (!data_in_valid) begin
                    gaps++;
                    chk("rd_idle_data", data_in_data, 32'd0);
`ifndef RBM_DMA_STALL_EN
                    chk("rd_valid_drop", 32'(prev_stall), 32'd0);
`endif
                end else begin
                    if (!seen) begin
                        seen = 1;
`ifndef RBM_DMA_STALL_EN
                        chk("rd_first_lat", n, 2);
`endif
                    end
                    if (prev_stall) chk("rd_hold_data", data_in_data, prev_d);
                    if (data_in_ready) begin
                        if (exp_q.size() == 0) chk("rd_extra", got + 1, len);
                        else                   chk("rd_data", data_in_data, exp_q.pop_front());
                        got++;
                    end
                    prev_stall = !data_in_ready;
                    prev_d     = data_in_data;
                end
            end
        end
    endtask

    // Two words with valid toggling 1,0,1; first accepted word collides with a load.
    task automatic run_write_stream(input int base, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        int            n = 1;
        int            idx = 0;
        int            writes = 0;
        int            a;
        bit            tog = 1;
        bit            ld_done = 0;
        bit            done = 0;
        logic [DW-1:0] w;
        while (!done) begin
            tick();
            n++;
            ld_en = 1'b0;
            if (!busy) begin
                done = 1;
                data_out_valid = 1'b0;
`ifndef RBM_DMA_STALL_EN
                chk("wr_busy_drop", n, 5);
`endif
                chk("wr_count", writes, 2);
            end else if (n > BUDGET) begin
                done = 1;
                data_out_valid = 1'b0;
                chk("wr_timeout", writes, 2);
            end else begin
`ifndef RBM_DMA_STALL_EN
                if (n == 2) chk("wr_first_ready", 32'(data_out_ready), 32'd1);
`endif
                chk("wr_no_grant", 32'({rd_grant, wr_grant}), 32'd0);
                a = (base + idx) % DEPTH;
                w = (idx == 0) ? w0 : w1;
                data_out_valid = tog && (idx < 2);
                data_out_data  = w;
                if (data_out_valid && data_out_ready) begin
                    model[a] = w;
                    if (writes == 0) begin
                        ld_en   = 1'b1;
                        ld_addr = AW'(a);
                        ld_data = ~w;
                    end
                    idx++;
                    writes++;
                end else if (!ld_done) begin
                    ld_en     = 1'b1;
                    ld_addr   = 4'd12;
                    ld_data   = 32'h5EED_0012 + 32'(base);
                    model[12] = ld_data;
                    ld_done   = 1;
                end
                tog = !tog;
            end
        end
        ld_en = 1'b0;
    endtask

    initial begin
        int gaps;
        int gap;
        int got;

        #2;
        chk("reset_outs", 32'({rd_grant, wr_grant, data_in_valid, data_out_ready, busy}), 32'd0);
        chk("reset_data", data_in_data, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            ld_en    = 1'b1;
            ld_addr  = AW'(i);
            ld_data  = 32'h1000_0000 + 32'(i);
            model[i] = ld_data;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            ld_en        = 1'b1;
            ld_addr      = AW'(4 + i);
            ld_data      = 32'hA0A0_0000 + 32'(i * 32'h0101_0101);
            model[4 + i] = ld_data;
            tick();
        end
        ld_en = 1'b0;
        chk("idle_after_load", 32'({busy, data_in_valid}), 32'd0);

        // Basic read of preloaded words
        push_exp(4, 3);
        request_read(32'd4, 32'd3);
        run_read_stream(3, 0, gaps);

        // Write two words, then confirm nothing is written outside a stream
        request_write(32'd10);
        run_write_stream(10, 32'hCAFE_0010, 32'hCAFE_0011);
        data_out_valid = 1'b1;
        data_out_data  = 32'hDEAD_BEEF;
        tick();
        chk("wr_idle_ready", 32'({data_out_ready, busy}), 32'd0);
        tick();
        data_out_valid = 1'b0;
        push_exp(9, 4);
        request_read(32'd9, 32'd4);
        run_read_stream(4, 0, gaps);

        // Simultaneous requests: read first, write after an idle cycle
        rd_index   = 32'd2;
        rd_length  = 32'd2;
        wr_index   = 32'd7;
        wr_length  = 32'd2;
        rd_request = 1'b1;
        wr_request = 1'b1;
        tick();
        chk("arb_rd_first", 32'({rd_grant, wr_grant}), 32'b10);
        rd_request = 1'b0;
        push_exp(2, 2);
        run_read_stream(2, 0, gaps);
        gap = 0;
        while (!wr_grant && gap < BUDGET) begin
            gap++;
            tick();
        end
        chk("arb_wr_after_gap", 32'((gap >= 1) && wr_grant), 32'd1);
        wr_request = 1'b0;
        run_write_stream(7, 32'hBEEF_0007, 32'hBEEF_0008);
        push_exp(6, 4);
        request_read(32'd6, 32'd4);
        run_read_stream(4, 0, gaps);

        // Address wrap, upper index bits ignored
        push_exp(15, 3);
        request_read(32'h0000_001F, 32'd3);
        run_read_stream(3, 0, gaps);

        // Zero-length read
        request_read(32'd5, 32'd0);
        tick();
        chk("len0_idle", 32'({busy, data_in_valid, rd_grant}), 32'd0);

        // Backpressure mid-stream
        push_exp(0, 6);
        request_read(32'd0, 32'd6);
        run_read_stream(6, 1, gaps);

        // Reset during a read stream
        request_read(32'd8, 32'd8);
        data_in_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (data_in_valid) begin
                chk("rst_pre_data", data_in_data, model[(8 + got) % DEPTH]);
                got++;
            end
            if (got == 3) break;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 32'({rd_grant, wr_grant, data_in_valid, data_out_ready, busy}), 32'd0);
        chk("rst_mid_data", data_in_data, 32'd0);
        data_in_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        push_exp(4, 3);
        request_read(32'd4, 32'd3);
        run_read_stream(3, 0, gaps);

        // Long stream with random ready
        push_exp(3, 64);
        request_read(32'd3, 32'd64);
        run_read_stream(64, 2, gaps);
`ifdef RBM_DMA_STALL_EN
        chk("stall_gaps_seen", 32'(gaps > 0), 32'd1);
`endif
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rbm_dma_responder.md
Name: rbm_dma_responder

Overview:
- Memory-side responder for the RBM accelerator DMA interface.
- Services the accelerator's read requests (rd_request/rd_index/rd_length) by granting and streaming words on data_in_*.
- Services write requests (wr_request/wr_index/wr_length) by granting and sinking words from data_out_*.
- Backs both paths with an internal word memory, plus a backdoor load port for bench/host preload; one transaction in flight at a time.

Parameters:
- DATA_W, 32, word width of the data_in/data_out buses and of the memory.
- ADDR_W, 12, memory address width; depth = 2**ADDR_W words.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rd_request  input  1  level; accelerator holds it until rd_grant.
- rd_index  input  32  start word address; low ADDR_W bits used.
- rd_length  input  32  word count.
- rd_grant  output  1  one-cycle pulse accepting the read.
- data_in_valid  output  1  read word valid.
- data_in_data  output  DATA_W  read word; 0 when data_in_valid=0.
- data_in_ready  input  1  accelerator accepts word.
- wr_request, wr_index, wr_length  input  1/32/32  write request; same rules as the read request.
- wr_grant  output  1  one-cycle pulse accepting the write.
- data_out_valid  input  1  accelerator write word valid.
- data_out_data  input  DATA_W  write word.
- data_out_ready  output  1  responder accepts the write word.
- ld_en, ld_addr, ld_data  input  1/ADDR_W/DATA_W  backdoor memory write.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-transfer):
  - State goes to IDLE; ptr and remaining clear.
  - rd_grant, wr_grant, data_in_valid, data_out_ready, busy all go to 0; data_in_data goes to 0.
  - Memory contents are not cleared.
- States:
  - IDLE -> RD_GNT if rd_request; else -> WR_GNT if wr_request. Reads win on a simultaneous request.
  - RD_GNT (1 cycle): rd_grant=1; latch ptr=rd_index[ADDR_W-1:0] and remaining=rd_length. Next state is RD_STRM, or IDLE if rd_length==0.
  - RD_STRM: data_in_valid=1, data_in_data=mem[ptr].
    - A transfer is data_in_valid & data_in_ready; on each transfer ptr++ and remaining--.
    - Valid stays high and data stays stable while ready=0.
    - The transfer with remaining==1 moves to IDLE.
  - WR_GNT / WR_STRM mirror the read path. In WR_STRM, data_out_ready=1 and each transfer writes mem[ptr]=data_out_data.
- Latency: request sampled high in IDLE at edge t gives grant high during cycle t+1. The first data_in_valid (or data_out_ready) is in cycle t+2.
- Minimum gap: at least one IDLE cycle between transactions. Requests seen outside IDLE are ignored; they stay pending because they are level signals.
- Address arithmetic: ptr wraps modulo 2**ADDR_W (mem[max] is followed by mem[0]). remaining is a 32-bit down-counter.
- Backdoor load:
  - ld_en writes mem[ld_addr] in any state.
  - If ld_en and a stream write hit the same address in the same cycle, the stream write wins.
  - A read stream sees a load made to mem[ptr] on the cycle after the load edge.
- Memory read is asynchronous: data_in_data is combinational from mem[ptr].

Optional Feature:
- Macro: RBM_DMA_STALL_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1, reset by rst) gates the streams. data_in_valid and data_out_ready are forced low in any stream cycle where lfsr[0]==0.
  - ptr/remaining never advance on a stalled cycle.
  - Handshake rules are unchanged; no word is lost or duplicated.
- When undefined: no stalls; data_in_valid and data_out_ready are held high for the entire stream state.

Decomposition:
- Package rbm_dma_pkg holds:
  - the state enum (IDLE, RD_GNT, RD_STRM, WR_GNT, WR_STRM);
  - the DATA_W/ADDR_W defaults;
  - the LFSR seed and tap constants.
- One sub-module: rbm_dma_mem, a 1W(stream)+1W(backdoor)+1R(async) memory with stream-write priority. The FSM, counters and LFSR stay in the top.

Test Plan:
- Preload mem[4..6]=A,B,C; rd_request, index 4, length 3, data_in_ready=1 -> rd_grant in cycle t+1; A,B,C at t+2..t+4; busy drops at t+5.
- wr_request, index 10, length 2 with words X,Y; data_out_valid toggles 1,0,1 -> wr_grant pulse; mem[10]=X, mem[11]=Y; exactly 2 writes.
- rd_request and wr_request raised in the same cycle -> read granted first; wr_grant follows after at least 1 IDLE cycle.
- ADDR_W=4, read index 15, length 3 -> words from mem[15], mem[0], mem[1]. rd_length=0 -> grant pulse, no data_in_valid, back to IDLE.
- Hold data_in_ready=0 for 5 cycles mid-stream -> data_in_data stable, no skip. Assert rst mid-stream -> all outputs 0 immediately; memory retained.
- With RBM_DMA_STALL_EN, stream 64 words with random ready -> all 64 words delivered in order; valid gaps observed.
